mult_booth: RTL and testbench

Sequential signed 32×32 multiplier for the multicycle MIPS datapath, implementing the `mult` instruction. It takes operands from the A and B registers, runs radix-2 Booth recoding over 32 iterations and produces a 64-bit product split into HI and LO. The control unit starts it with `mult_control`, then waits for `mult_end` before asserting `HI_reg_w` and `LO_reg_w`.

---
 rtl/mult_booth_pkg.sv | 13 +
 rtl/mult_booth_step.sv | 30 +++
 rtl/mult_booth.sv | 106 ++++++++++
 tb/tb_mult_booth.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mult_booth_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM encoding and step count.
package mult_booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } mult_state_e;

    localparam int MULT_STEPS = 32;

endpackage

// File: rtl/mult_booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into ACC, then an
// arithmetic right shift of {ACC, Q, q_1}. Purely combinational.
module booth_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             q1_i,
    input  logic [WIDTH:0]   m_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] q_o,
    output logic             q1_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = acc_i;
        case ({q_i[0], q1_i})
            2'b01:   sum = acc_i + m_i;
            2'b10:   sum = acc_i - m_i;
            default: sum = acc_i;
        endcase
        // ACC keeps its sign bit; its LSB slides into the top of Q.
        acc_o = {sum[WIDTH], sum[WIDTH:1]};
        q_o   = {sum[0], q_i[WIDTH-1:1]};
        q1_o  = q_i[0];
    end

endmodule

// File: rtl/mult_booth.sv
// Sequential signed WIDTHxWIDTH multiplier for the MIPS `mult` instruction.
// Radix-2 Booth, one step per cycle; HI/LO are registered at DONE entry.
module mult_booth
    import mult_booth_pkg::*;
#(
    parameter int WIDTH = MULT_STEPS
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             mult_control,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             mult_end,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    mult_state_e      state_q;
    logic [WIDTH:0]   m_q;
    logic [WIDTH:0]   acc_q;
    logic [WIDTH-1:0] q_q;
    logic             q1_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             mult_end_q;
    logic             busy_q;

    logic [WIDTH:0]   acc_d;
    logic [WIDTH-1:0] q_d;
    logic             q1_d;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc_i (acc_q),
        .q_i   (q_q),
        .q1_i  (q1_q),
        .m_i   (m_q),
        .acc_o (acc_d),
        .q_o   (q_d),
        .q1_o  (q1_d)
    );

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q    <= IDLE;
            m_q        <= '0;
            acc_q      <= '0;
            q_q        <= '0;
            q1_q       <= 1'b0;
            count_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            mult_end_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            mult_end_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mult_control) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    m_q     <= {a_in[WIDTH-1], a_in};
                    acc_q   <= '0;
                    q_q     <= b_in;
                    q1_q    <= 1'b0;
                    count_q <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    acc_q   <= acc_d;
                    q_q     <= q_d;
                    q1_q    <= q1_d;
                    count_q <= count_q + 1'b1;
                    // Final step: capture the product straight from the step output.
                    if (count_q == LAST_STEP) begin
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        hi_q       <= acc_d[WIDTH-1:0];
                        lo_q       <= q_d;
                        mult_end_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign mult_end = mult_end_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mult_booth.sv
// Directed + random checks of mult_booth: products, latency, busy, start-while-busy, reset.
module tb_mult_booth;

    logic        clk;
    logic        reset_in;
    logic        mult_control;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        mult_end;
    logic        busy;

    int errors = 0;
    int checks = 0;

    mult_booth #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset_in     (reset_in),
        .mult_control (mult_control),
        .a_in         (a_in),
        .b_in         (b_in),
        .hi_out       (hi_out),
        .lo_out       (lo_out),
        .mult_end     (mult_end),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start a multiply, wait (bounded) for mult_end, check latency/busy/product.
    task automatic do_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp);
        int cyc;
        bit seen;
        @(negedge clk);
        a_in = a; b_in = b; mult_control = 1'b1;
        @(posedge clk);                      // E0
        #1 mult_control = 1'b0;
        chk({tag, " busy_after_start"}, 64'(busy), 64'd1);
        cyc = 0; seen = 0;
        while (!seen && cyc < 100) begin
            @(posedge clk);
            cyc++;
            #1;
            if (mult_end) seen = 1;
        end
        chk({tag, " latency"}, 64'(cyc), 64'd33);
        chk({tag, " busy_in_done"}, 64'(busy), 64'd0);
        chk({tag, " product"}, {hi_out, lo_out}, exp);
        @(posedge clk);                      // E34
        #1;
        chk({tag, " end_fell"}, 64'(mult_end), 64'd0);
        chk({tag, " product_hold"}, {hi_out, lo_out}, exp);
    endtask

    initial begin
        int n_end;
        int cyc;
        bit seen;
        logic [31:0] ra, rb;
        longint      prod;

        reset_in = 1'b0; mult_control = 1'b0; a_in = '0; b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {hi_out, lo_out}, 64'd0);
        chk("reset end/busy", {62'd0, mult_end, busy}, 64'd0);
        @(negedge clk);
        reset_in = 1'b1;

        do_mult("3x4",       32'd3,          32'd4,          64'h00000000_0000000C);
        do_mult("-1x1",      32'hFFFFFFFF,   32'h00000001,   64'hFFFFFFFF_FFFFFFFF);
        do_mult("min x min", 32'h80000000,   32'h80000000,   64'h40000000_00000000);
        do_mult("max x max", 32'h7FFFFFFF,   32'h7FFFFFFF,   64'h3FFFFFFF_00000001);

        // mult_control held high throughout; operands change mid-run.
        @(negedge clk);
        a_in = 32'h00001234; b_in = 32'hFFFFFFFE; mult_control = 1'b1;
        @(posedge clk);                      // E0
        n_end = 0;
        for (int c = 1; c <= 34; c++) begin
            @(posedge clk);
            #1;
            if (c == 10) begin a_in = 32'd100; b_in = 32'd100; end
            if (mult_end) n_end++;
            if (c == 33)
                chk("hold product", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFDB98);
        end
        chk("hold single end", 64'(n_end), 64'd1);
        chk("hold idle busy", 64'(busy), 64'd0);
        @(posedge clk);                      // E35: restart accepted from IDLE
        #1 mult_control = 1'b0;
        chk("hold restart busy", 64'(busy), 64'd1);
        cyc = 0; seen = 0;
        while (!seen && cyc < 100) begin
            @(posedge clk);
            cyc++;
            #1;
            if (mult_end) seen = 1;
        end
        chk("restart latency", 64'(cyc), 64'd33);
        chk("restart product", {hi_out, lo_out}, 64'd10000);

        // Reset in the middle of RUN.
        @(negedge clk);
        a_in = 32'h00012345; b_in = 32'h00000777; mult_control = 1'b1;
        @(posedge clk);                      // E0
        #1 mult_control = 1'b0;
        repeat (16) @(posedge clk);          // LOAD + 15 RUN steps
        #1 reset_in = 1'b0;
        #1;
        chk("midrst outputs", {hi_out, lo_out}, 64'd0);
        chk("midrst end/busy", {62'd0, mult_end, busy}, 64'd0);
        n_end = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (mult_end) n_end++;
        end
        chk("midrst no end", 64'(n_end), 64'd0);
        @(negedge clk);
        reset_in = 1'b1;
        do_mult("5x-7", 32'd5, 32'hFFFFFFF9, 64'hFFFFFFFF_FFFFFFDD);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom();
            rb = $urandom();
            if (i == 0) ra = 32'h80000000;
            if (i == 1) rb = 32'h80000000;
            prod = longint'($signed(ra)) * longint'($signed(rb));
            do_mult("random", ra, rb, 64'(prod));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
